// File: rtl/period_meter.sv
// Averages input period and high time over 2**NPER_LOG2 rising-edge intervals.
// Results register one cycle after the terminating rise; timeout strobes when no measurement completes.
module period_meter #(
  parameter int          CNT_W     = 24,
  parameter int          NPER_LOG2 = 2,
  parameter int unsigned TIMEOUT   = (2**24) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_avg,
  output logic [CNT_W-1:0] high_avg,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int EW = (NPER_LOG2 > 0) ? NPER_LOG2 : 1;
  localparam logic [EW-1:0]    LAST_EDGE = EW'((2**NPER_LOG2) - 1);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LIM_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sig_q;
  logic [CNT_W-1:0] acc_p_q, acc_p_d;
  logic [CNT_W-1:0] acc_h_q, acc_h_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;
  logic             rise;

  assign rise = sig_in & ~sig_q;

  always_comb begin
    state_d = state_q;
    acc_p_d = acc_p_q;
    acc_h_d = acc_h_q;
    edge_d  = edge_q;
    wait_d  = wait_q;
    per_d   = per_q;
    high_d  = high_q;
    valid_d = 1'b0;
    tout_d  = tout_q;

    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d = ARM;
          wait_d  = '0;
        end
      end

      ARM: begin
        if (!ena) begin
          state_d = IDLE;
          acc_p_d = '0;
          acc_h_d = '0;
          edge_d  = '0;
          wait_d  = '0;
        end else if (rise) begin
          state_d = MEAS;
          acc_p_d = ONE;
          acc_h_d = ONE;
          edge_d  = '0;
        end else if (wait_q == TO_LIM_M1) begin
          valid_d = 1'b1;
          tout_d  = 1'b1;
          per_d   = '0;
          high_d  = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + ONE;
        end
      end

      MEAS: begin
        if (!ena) begin
          state_d = IDLE;
          acc_p_d = '0;
          acc_h_d = '0;
          edge_d  = '0;
          wait_d  = '0;
        end else if (rise) begin
          // The terminating rise also opens the next window, so no edge is lost.
          if (edge_q == LAST_EDGE) begin
            valid_d = 1'b1;
            tout_d  = 1'b0;
            per_d   = acc_p_q >> NPER_LOG2;
            high_d  = acc_h_q >> NPER_LOG2;
            acc_p_d = ONE;
            acc_h_d = ONE;
            edge_d  = '0;
          end else begin
            edge_d  = edge_q + EW'(1);
            acc_p_d = acc_p_q + ONE;
            acc_h_d = acc_h_q + ONE;
          end
        end else if (acc_p_q == TO_LIM) begin
          state_d = ARM;
          valid_d = 1'b1;
          tout_d  = 1'b1;
          per_d   = '0;
          high_d  = '0;
          acc_p_d = '0;
          acc_h_d = '0;
          edge_d  = '0;
          wait_d  = '0;
        end else begin
          acc_p_d = acc_p_q + ONE;
          acc_h_d = acc_h_q + CNT_W'(sig_in);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sig_q   <= 1'b1;
      acc_p_q <= '0;
      acc_h_q <= '0;
      edge_q  <= '0;
      wait_q  <= '0;
      per_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_in;
      acc_p_q <= acc_p_d;
      acc_h_q <= acc_h_d;
      edge_q  <= edge_d;
      wait_q  <= wait_d;
      per_q   <= per_d;
      high_q  <= high_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  assign period_avg = per_q;
  assign high_avg   = high_q;
  assign valid      = valid_q;
  assign timeout    = tout_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: table of 4-period records plus hand sequences for reset, enable drop and timeouts.
module tb_period_meter;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        sig_in;
  logic [23:0] period_avg;
  logic [23:0] high_avg;
  logic        valid;
  logic        timeout;
  logic        busy;

  period_meter #(
    .CNT_W    (24),
    .NPER_LOG2(2),
    .TIMEOUT  (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sig_in    (sig_in),
    .period_avg(period_avg),
    .high_avg  (high_avg),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  typedef struct {
    int cyc;
    int per;
    int hi;
    int to;
  } exp_t;

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
    int h;
    int exp_p;
    int exp_h;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   cyc;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected result, including its cycle.
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1 per=%0d hi=%0d to=%0d, expected no strobe (cycle %0d)",
                 period_avg, high_avg, timeout, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("period_avg", int'(period_avg), e.per);
        check("high_avg", int'(high_avg), e.hi);
        check("timeout", int'(timeout), e.to);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(input int p, input int h);
    sig_in = 1'b1;
    for (int i = 0; i < h; i++) tick();
    sig_in = 1'b0;
    for (int i = 0; i < p - h; i++) tick();
  endtask

  initial begin
    int pp[4];
    int pe;
    int ph;
    bit pend;
    int c1;

    n_cmp = 0;
    n_err = 0;

    tbl[0] = '{10, 10, 10, 10, 3, 10, 3};
    tbl[1] = '{10, 10, 10, 10, 3, 10, 3};
    tbl[2] = '{ 9,  9,  9, 10, 4,  9, 4};
    tbl[3] = '{ 9, 10, 11, 10, 4, 10, 4};
    tbl[4] = '{ 5,  6,  7,  7, 2,  6, 2};
    tbl[5] = '{ 2,  2,  2,  2, 1,  2, 1};
    tbl[6] = '{20, 21, 22, 23, 7, 21, 7};
    tbl[7] = '{25, 25, 25, 25, 5, 25, 5};
    tbl[8] = '{ 3,  3,  3,  3, 1,  3, 1};

    // Reset with the input held high.
    rst    = 1'b0;
    ena    = 1'b0;
    sig_in = 1'b1;
    tick(); tick(); tick();
    check("rst_period", int'(period_avg), 0);
    check("rst_high", int'(high_avg), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_busy", int'(busy), 0);

    rst = 1'b1;
    ena = 1'b1;
    tick(); tick();
    check("arm_busy", int'(busy), 1);
    tick(); tick(); tick();
    sig_in = 1'b0;
    tick();

    // Back-to-back records: the final rise of one record opens the next.
    pend = 1'b0;
    pe   = 0;
    ph   = 0;
    for (int r = 0; r < 9; r++) begin
      pp = '{tbl[r].p0, tbl[r].p1, tbl[r].p2, tbl[r].p3};
      for (int k = 0; k < 4; k++) begin
        if (k == 0 && pend) sb.push_back('{cyc + 1, pe, ph, 0});
        run_period(pp[k], tbl[r].h);
      end
      pe   = tbl[r].exp_p;
      ph   = tbl[r].exp_h;
      pend = 1'b1;
    end
    sb.push_back('{cyc + 1, pe, ph, 0});
    sig_in = 1'b1;
    tick(); tick();
    sig_in = 1'b0;
    tick(); tick(); tick();

    // Enable dropped mid-measurement: idle next cycle, results held, no strobe.
    ena = 1'b0;
    tick();
    check("ena_drop_busy", int'(busy), 0);
    for (int i = 0; i < 10; i++) tick();
    check("hold_period", int'(period_avg), 3);
    check("hold_high", int'(high_avg), 1);
    check("hold_timeout", int'(timeout), 0);

    // One-cycle reset mid-measurement, then a clean measurement.
    ena = 1'b1;
    tick(); tick();
    sig_in = 1'b1;
    tick(); tick(); tick();
    sig_in = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("midrst_period", int'(period_avg), 0);
    check("midrst_high", int'(high_avg), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b1;
    tick(); tick();
    for (int k = 0; k < 4; k++) run_period(8, 3);
    sb.push_back('{cyc + 1, 8, 3, 0});
    sig_in = 1'b1;
    tick(); tick();
    sig_in = 1'b0;
    tick(); tick();

    // Idle input in ARM: timeout strobe every 100 cycles.
    ena = 1'b0;
    tick();
    ena = 1'b1;
    c1  = cyc;
    sb.push_back('{c1 + 101, 0, 0, 1});
    sb.push_back('{c1 + 201, 0, 0, 1});
    for (int i = 0; i < 150; i++) tick();
    check("to_hold_flag", int'(timeout), 1);
    check("to_hold_period", int'(period_avg), 0);
    check("to_hold_high", int'(high_avg), 0);
    for (int i = 0; i < 55; i++) tick();
    ena = 1'b0;
    tick(); tick();

    // Period 120 exceeds the range: each window ends in a timeout from MEAS.
    ena = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{cyc + 101, 0, 0, 1});
      run_period(120, 60);
    end
    ena = 1'b0;
    tick(); tick(); tick();
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
